// File: rtl/mem_write_controller_if.sv
// Store-path bus between the memory stage and mem_write_controller: store request,
// lane-aligned memory write port, UART transmit handshake and pipeline control.
interface mem_write_controller_if #(
  parameter int WADDR_W = 14
);
  logic               st_valid;
  logic [31:0]        instruction;
  logic [31:0]        mem_addr;
  logic [31:0]        store_data;
  logic [31:0]        mem_wdata;
  logic [WADDR_W-1:0] mem_waddr;
  logic [3:0]         dmem_we;
  logic [3:0]         imem_we;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_valid;
  logic               uart_tx_ready;
  logic               counter_rst;
  logic               stall;
  logic               misalign_err;

  modport master (
    output st_valid, instruction, mem_addr, store_data, uart_tx_ready,
    input  mem_wdata, mem_waddr, dmem_we, imem_we, uart_tx_data, uart_tx_valid,
           counter_rst, stall, misalign_err
  );

  modport slave (
    input  st_valid, instruction, mem_addr, store_data, uart_tx_ready,
    output mem_wdata, mem_waddr, dmem_we, imem_we, uart_tx_data, uart_tx_valid,
           counter_rst, stall, misalign_err
  );
endinterface

// File: rtl/mem_write_controller.sv
// Store decode, byte-lane alignment, DMEM/IMEM write enables and UART TX handshake.
// Optional macro STORE_MISALIGN_TRAP_EN: suppress misaligned SH/SW and pulse misalign_err.
module mem_write_controller #(
  parameter int WADDR_W = 14
) (
  input logic             clk,
  input logic             rst,
  mem_write_controller_if.slave bus
);
  localparam logic [6:0]  OPC_STORE    = 7'b0100011;
  localparam logic [31:0] UART_TX_ADDR = 32'h8000_0008;
  localparam logic [31:0] CNT_RST_ADDR = 32'h8000_0018;

  typedef enum logic {S_IDLE, S_PEND} tx_state_t;
  tx_state_t state, state_nxt;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  lane_mask = 4'b0001 << off;
      3'b001:  lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    case (f3)
      3'b000:  lane_data = {4{d[7:0]}};
      3'b001:  lane_data = {16'h0000, d[15:0]} << {off, 3'b000};
      default: lane_data = d;
    endcase
  endfunction

  logic [2:0] funct3;
  logic [1:0] byte_off, eff_off;
  logic       stall_c, is_store, misaligned, do_store, trap;
  logic       hit_dmem, hit_imem, hit_uart, hit_cnt;
  logic       tx_load, tx_xfer;
  logic       unused_insn_bits;

  assign funct3     = bus.instruction[14:12];
  assign byte_off   = bus.mem_addr[1:0];
  assign stall_c    = (state == S_PEND) && !bus.uart_tx_ready;
  assign is_store   = bus.st_valid && !stall_c && (bus.instruction[6:0] == OPC_STORE) &&
                      (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
  assign misaligned = (funct3 == 3'b001 && byte_off == 2'b11) ||
                      (funct3 == 3'b010 && byte_off != 2'b00);
  assign eff_off    = misaligned ? 2'b00 : byte_off;

`ifdef STORE_MISALIGN_TRAP_EN
  assign do_store = is_store && !misaligned;
  assign trap     = is_store && misaligned;
`else
  assign do_store = is_store;
  assign trap     = 1'b0;
`endif

  // 4'b00X1 selects DMEM, 4'b001X selects IMEM; 4'b0011 hits both
  assign hit_dmem = (bus.mem_addr[31:30] == 2'b00) && bus.mem_addr[28];
  assign hit_imem = (bus.mem_addr[31:29] == 3'b001);
  assign hit_uart = (bus.mem_addr == UART_TX_ADDR);
  assign hit_cnt  = (bus.mem_addr == CNT_RST_ADDR);
  assign tx_xfer  = (state == S_PEND) && bus.uart_tx_ready;

  assign unused_insn_bits = ^{bus.instruction[31:15], bus.instruction[11:7]};

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (do_store && hit_uart) begin
          tx_load   = 1'b1;
          state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (tx_xfer) begin
          if (do_store && hit_uart) tx_load   = 1'b1;
          else                      state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // p0 -> p1: decoded store registered onto the memory write port
  logic [31:0]        wdata_p1;
  logic [WADDR_W-1:0] waddr_p1;
  logic [3:0]         dmem_we_p1, imem_we_p1;
  logic [7:0]         tx_data_p1;
  logic               cnt_rst_p1, trap_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_p1   <= '0;
      waddr_p1   <= '0;
      dmem_we_p1 <= 4'b0000;
      imem_we_p1 <= 4'b0000;
      tx_data_p1 <= 8'h00;
      cnt_rst_p1 <= 1'b0;
      trap_p1    <= 1'b0;
    end else begin
      dmem_we_p1 <= (do_store && hit_dmem) ? lane_mask(funct3, eff_off) : 4'b0000;
      imem_we_p1 <= (do_store && hit_imem) ? lane_mask(funct3, eff_off) : 4'b0000;
      cnt_rst_p1 <= do_store && hit_cnt;
      trap_p1    <= trap;
      if (do_store) begin
        wdata_p1 <= lane_data(funct3, eff_off, bus.store_data);
        waddr_p1 <= bus.mem_addr[WADDR_W+1:2];
      end
      if (tx_load) tx_data_p1 <= bus.store_data[7:0];
    end
  end

  assign bus.mem_wdata     = wdata_p1;
  assign bus.mem_waddr     = waddr_p1;
  assign bus.dmem_we       = dmem_we_p1;
  assign bus.imem_we       = imem_we_p1;
  assign bus.uart_tx_data  = tx_data_p1;
  assign bus.uart_tx_valid = (state == S_PEND);
  assign bus.counter_rst   = cnt_rst_p1;
  assign bus.stall         = stall_c;
`ifdef STORE_MISALIGN_TRAP_EN
  assign bus.misalign_err  = trap_p1;
`else
  assign bus.misalign_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_write_controller.sv
// Scoreboard bench for mem_write_controller: expected next-cycle outputs are queued
// as each stimulus cycle is driven and popped once the DUT has registered them.
module tb_mem_write_controller;
  localparam int         WADDR_W = 14;
  localparam logic [6:0] ST      = 7'b0100011;
  localparam logic [6:0] LD      = 7'b0000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_write_controller_if #(.WADDR_W(WADDR_W)) bus ();
  mem_write_controller #(.WADDR_W(WADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic [3:0]         dmem_we;
    logic [3:0]         imem_we;
    logic [31:0]        wdata;
    logic [WADDR_W-1:0] waddr;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               crst;
    logic               merr;
    logic               chk_data;
    logic               chk_tx;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         dut_xfers = 0;
  int         m_xfers   = 0;
  logic       m_pend = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk)
    if (bus.uart_tx_valid === 1'b1 && bus.uart_tx_ready === 1'b1) dut_xfers <= dut_xfers + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    exp_t        e;
    logic        stall_m, acc, mis;
    logic [1:0]  o;
    logic [3:0]  mask, top;
    logic [31:0] wd;
    logic [15:0] h;
    rst               = r;
    bus.st_valid      = v;
    bus.instruction   = {17'($urandom), f3, 5'($urandom), op};
    bus.mem_addr      = addr;
    bus.store_data    = data;
    bus.uart_tx_ready = rdy;
    #1;
    stall_m = m_pend && !rdy;
    check_val("stall", 32'(bus.stall), 32'(stall_m));

    e   = '0;
    o   = addr[1:0];
    acc = !r && v && !stall_m && (op == ST) && (f3 <= 3'd2);
    mis = (f3 == 3'd1 && o == 2'd3) || (f3 == 3'd2 && o != 2'd0);
`ifdef STORE_MISALIGN_TRAP_EN
    if (acc && mis) begin
      e.merr = 1'b1;
      acc    = 1'b0;
    end
`else
    if (mis) o = 2'd0;
`endif
    h    = data[15:0];
    mask = 4'b0000;
    wd   = data;
    if (f3 == 3'd0) begin
      wd = data[7:0] * 32'h0101_0101;
      case (o)
        2'd0: mask = 4'b0001;
        2'd1: mask = 4'b0010;
        2'd2: mask = 4'b0100;
        default: mask = 4'b1000;
      endcase
    end else if (f3 == 3'd1) begin
      case (o)
        2'd0: begin mask = 4'b0011; wd = {16'h0000, h}; end
        2'd1: begin mask = 4'b0110; wd = {8'h00, h, 8'h00}; end
        default: begin mask = 4'b1100; wd = {h, 16'h0000}; end
      endcase
    end else begin
      mask = 4'b1111;
    end
    top = addr[31:28];
    if (acc && (top == 4'h1 || top == 4'h3)) e.dmem_we = mask;
    if (acc && (top == 4'h2 || top == 4'h3)) e.imem_we = mask;
    if (acc && (top == 4'h1 || top == 4'h2 || top == 4'h3)) begin
      e.chk_data = 1'b1;
      e.wdata    = wd;
      e.waddr    = addr[WADDR_W+1:2];
    end
    e.crst = acc && (addr == 32'h8000_0018);

    if (m_pend && rdy) m_xfers++;
    if (r) begin
      m_pend     = 1'b0;
      m_data     = 8'h00;
      e.chk_data = 1'b1;
    end else if (acc && addr == 32'h8000_0008) begin
      m_pend = 1'b1;
      m_data = data[7:0];
    end else if (m_pend && rdy) begin
      m_pend = 1'b0;
    end
    e.tx_valid = m_pend;
    e.tx_data  = m_data;
    e.chk_tx   = m_pend || r;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("dmem_we", 32'(bus.dmem_we), 32'(e.dmem_we));
    check_val("imem_we", 32'(bus.imem_we), 32'(e.imem_we));
    check_val("counter_rst", 32'(bus.counter_rst), 32'(e.crst));
    check_val("misalign_err", 32'(bus.misalign_err), 32'(e.merr));
    check_val("uart_tx_valid", 32'(bus.uart_tx_valid), 32'(e.tx_valid));
    if (e.chk_tx) check_val("uart_tx_data", 32'(bus.uart_tx_data), 32'(e.tx_data));
    if (e.chk_data) begin
      check_val("mem_wdata", bus.mem_wdata, e.wdata);
      check_val("mem_waddr", 32'(bus.mem_waddr), 32'(e.waddr));
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, ST, 3'd2, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    bus.st_valid      = 1'b0;
    bus.instruction   = 32'h0;
    bus.mem_addr      = 32'h0;
    bus.store_data    = 32'h0;
    bus.uart_tx_ready = 1'b0;
    rst               = 1'b1;
    @(posedge clk);
    #1;

    // reset state; a store presented during reset is ignored
    step(1'b1, 1'b1, ST, 3'd2, 32'h1000_0000, 32'hDEAD_BEEF, 1'b0);
    idle(1'b0);

    step(1'b0, 1'b1, ST, 3'd0, 32'h1000_0003, 32'h0000_00A5, 1'b0);
    step(1'b0, 1'b1, ST, 3'd1, 32'h3000_0006, 32'h1234_BEEF, 1'b0);
    step(1'b0, 1'b1, ST, 3'd1, 32'h2000_0005, 32'h0000_C0DE, 1'b0);
    step(1'b0, 1'b1, ST, 3'd2, 32'h1000_0104, 32'hCAFE_F00D, 1'b0);
    idle(1'b0);

    // UART store with the transmitter busy for three cycles
    step(1'b0, 1'b1, ST, 3'd2, 32'h8000_0008, 32'h0000_0041, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, ST, 3'd2, 32'h1000_0000, 32'h1111_1111, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    check_val("xfer_count_a", 32'(dut_xfers), 32'(m_xfers));

    // back-to-back UART stores with ready held high
    step(1'b0, 1'b1, ST, 3'd0, 32'h8000_0008, 32'h0000_0041, 1'b1);
    step(1'b0, 1'b1, ST, 3'd1, 32'h8000_0008, 32'h0000_0042, 1'b1);
    idle(1'b1);
    check_val("xfer_count_b", 32'(dut_xfers), 32'(m_xfers));

    step(1'b0, 1'b1, ST, 3'd2, 32'h8000_0018, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, ST, 3'd2, 32'h4000_0000, 32'h5555_AAAA, 1'b0);
    step(1'b0, 1'b1, ST, 3'd2, 32'h1000_0002, 32'h8765_4321, 1'b0);
    step(1'b0, 1'b1, ST, 3'd1, 32'h1000_0007, 32'h0000_ABCD, 1'b0);
    step(1'b0, 1'b1, LD, 3'd2, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, ST, 3'd3, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(1'b0);

    // reset while a byte is pending
    step(1'b0, 1'b1, ST, 3'd2, 32'h8000_0008, 32'h0000_0055, 1'b0);
    step(1'b1, 1'b0, ST, 3'd2, 32'h0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    check_val("xfer_count_c", 32'(dut_xfers), 32'(m_xfers));

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 6))
        0: a = 32'h1000_0000 | 32'($urandom_range(0, 65535));
        1: a = 32'h2000_0000 | 32'($urandom_range(0, 65535));
        2: a = 32'h3000_0000 | 32'($urandom_range(0, 65535));
        3: a = 32'h8000_0008;
        4: a = 32'h8000_0018;
        5: a = 32'h4000_0000 | 32'($urandom_range(0, 65535));
        default: a = 32'h5000_0000 | 32'($urandom_range(0, 65535));
      endcase
      step(1'b0, 1'($urandom), ($urandom_range(0, 3) == 0) ? LD : ST,
           3'($urandom_range(0, 3)), a, $urandom, 1'($urandom));
    end
    idle(1'b1);
    idle(1'b1);
    check_val("xfer_count_final", 32'(dut_xfers), 32'(m_xfers));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_write_controller.md
# mem_write_controller

Store-side counterpart of the load path in the RISC-V core's memory stage. It decodes store instructions, aligns store data into byte lanes and generates per-byte write enables for data memory and instruction memory. It also drives the UART transmit valid/ready handshake, stalling the pipeline while a transmit byte is pending, and pulses the counter-reset strobe.

## Interface
Parameters:
- `WADDR_W`, 14: word-address width driven to DMEM/IMEM (`mem_addr[WADDR_W+1:2]`).

Ports:
- `clk`  in  1  core clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  `instruction`, `mem_addr` and `store_data` are valid this cycle (pipeline not stalled).
- `instruction`  in  32  instruction in the memory stage.
- `mem_addr`  in  32  effective byte address.
- `store_data`  in  32  rs2 value, unaligned (value in the low bits).
- `mem_wdata`  out  32  lane-aligned write data, registered.
- `mem_waddr`  out  WADDR_W  word address, registered.
- `dmem_we`  out  4  DMEM byte write enables, registered.
- `imem_we`  out  4  IMEM byte write enables, registered.
- `uart_tx_data`  out  8  byte to transmit.
- `uart_tx_valid`  out  1  transmit byte pending.
- `uart_tx_ready`  in  1  UART transmitter can accept a byte.
- `counter_rst`  out  1  one-cycle pulse that resets the cycle and instruction counters.
- `stall`  out  1  pipeline must hold the current memory-stage contents.
- `misalign_err`  out  1  one-cycle pulse on a suppressed misaligned store (`STORE_MISALIGN_TRAP_EN` only).

## Operation
- Store accepted when `st_valid` is 1, `instruction[6:0]` is 7'b0100011 and `stall` is 0. Any other opcode produces no effect.
- funct3 000 = SB, 001 = SH, 010 = SW. Any other funct3 produces no effect.

Byte mask and data, with `o = mem_addr[1:0]`:
- SB: mask `1<<o`; data is the low byte replicated in all four lanes.
- SH: `o` = 0 → mask 0011, `o` = 1 → 0110, `o` = 2 → 1100, `o` = 3 → misaligned. Data is the low halfword shifted left by 8·`o`.
- SW: `o` = 0 → mask 1111. Any nonzero `o` is misaligned.
- Misaligned default (macro off): the byte offset is zeroed. SH writes mask 0011 with unshifted data; SW writes mask 1111.

Address decode on `mem_addr[31:28]`:
- 4'b00X1: mask goes to `dmem_we`.
- 4'b001X: mask goes to `imem_we`.
- 4'b0011 matches both rules, so it writes DMEM and IMEM together.
- 0x80000008, any store width: `store_data[7:0]` is sent to the UART transmit path.
- 0x80000018: `counter_rst` pulses.
- Anything else, including BIOS region 4'b0100: dropped silently.

UART transmit FSM:
- IDLE: on an accepted UART store, latch the byte into `uart_tx_data` and go to PEND.
- PEND: `uart_tx_valid` = 1. The transfer happens in any cycle where `uart_tx_valid` and `uart_tx_ready` are both 1.
  - After a transfer, go to IDLE, unless another UART store is accepted in the same cycle; then latch the new byte and stay in PEND.
- `stall` = (state == PEND) && !`uart_tx_ready`, combinational.
- While `stall` = 1, `st_valid` is ignored and no memory enables are generated.

## Timing
- Latency is 1 cycle. A store accepted in cycle N drives `dmem_we`/`imem_we`/`mem_wdata`/`mem_waddr` during cycle N+1; the memories commit at the end of N+1.
- Enables and `counter_rst` are high for exactly one cycle per accepted store. They are 0 in every cycle without an accepted store.
- A UART store accepted in cycle N raises `uart_tx_valid` in N+1. At most one byte transfers per handshake cycle. `uart_tx_data` is stable while `uart_tx_valid` = 1.
- Reset (synchronous, any cycle, including mid-PEND): state IDLE, pending byte discarded. All outputs 0: `mem_wdata`, `mem_waddr`, `dmem_we`, `imem_we`, `uart_tx_data`, `uart_tx_valid`, `counter_rst`, `stall`, `misalign_err`.
- `st_valid` asserted in the reset cycle is ignored.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined: a misaligned SH/SW produces no enables, no UART transfer and no `counter_rst`. `misalign_err` pulses in N+1.
- Not defined: the misaligned default from Operation applies, and `misalign_err` is tied to 0.

## Test plan
- SB to 0x10000003, `store_data` = 0x000000A5 → next cycle `dmem_we` = 1000, `mem_wdata` = 0xA5A5A5A5, `mem_waddr` = 0x0000, `imem_we` = 0000.
- SH to 0x30000006, data 0x1234BEEF → `dmem_we` = `imem_we` = 1100, `mem_wdata` = 0xBEEF0000, `mem_waddr` = 1.
- SW to 0x80000008, data 0x41, `uart_tx_ready` low for 3 cycles → `uart_tx_valid` = 1 and `uart_tx_data` = 0x41 from N+1. `stall` = 1 until `uart_tx_ready` rises. One transfer occurs, then IDLE.
- Back-to-back UART stores 0x41 then 0x42 with `uart_tx_ready` = 1 → two transfers in consecutive cycles, no stall.
- SW to 0x80000018 → `counter_rst` is a single-cycle pulse. SW to 0x40000000 → no enables.
- SW to 0x10000002:
  - Macro off → `dmem_we` = 1111, `mem_waddr` = 0.
  - Macro on → `dmem_we` = 0000, `misalign_err` pulses.
- Assert `rst` during PEND → `uart_tx_valid` and `stall` are 0 the next cycle, and no transfer occurs.
